// File: rtl/weight_bank_loader_pkg.sv
// Shared definitions for the weight bank loader: default geometry, FSM encodings
// and the debug snapshot exported by the top level.
package weight_bank_loader_pkg;

    localparam int WBL_WORD_W = 256;
    localparam int WBL_DEPTH  = 64;
    localparam int WBL_ADDR_W = $clog2(WBL_DEPTH);

    typedef enum logic {
        W_FILL  = 1'b0,
        W_STALL = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } rd_state_e;

    typedef struct packed {
        wr_state_e  wr_state;
        rd_state_e  rd_state;
        logic       wr_bank;
        logic       rd_bank;
        logic [1:0] full;
    } dbg_t;

endpackage

// File: rtl/weight_bank_loader_if.sv
// Upstream word stream plus compute-side bank read port of the weight bank loader.
interface weight_bank_loader_if
    import weight_bank_loader_pkg::*;
#(
    parameter int WORD_W = WBL_WORD_W,
    parameter int ADDR_W = WBL_ADDR_W
) ();

    // din is transferred on a rising edge where din_vld and ready are both 1;
    // ready depends only on registered state, and upstream keeps din_vld low while ready is 0.
    logic [WORD_W-1:0] din;
    logic              din_vld;
    logic              ready;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              bank_vld;
    logic              bank_done;

    logic [ADDR_W:0]   fill_cnt;
    logic              err;

    modport master (
        output din, din_vld, rd_en, rd_addr, bank_done,
        input  ready, rd_data, bank_vld, fill_cnt, err
    );

    modport slave (
        input  din, din_vld, rd_en, rd_addr, bank_done,
        output ready, rd_data, bank_vld, fill_cnt, err
    );

endinterface

// File: rtl/weight_bank_ram.sv
// Simple dual-port storage for both banks, addressed as {bank, word}; the read
// port is registered and its output register is cleared by reset.
module weight_bank_ram #(
    parameter int WORD_W = 256,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W:0]   waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W:0]   raddr,
    output logic [WORD_W-1:0] rdata
);

    localparam int ENTRIES = 2 ** (ADDR_W + 1);

    logic [WORD_W-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/weight_bank_loader.sv
// Double-buffered weight loader: fills one bank from the upstream word stream
// while the compute side reads the other bank, swapping on bank completion/release.
module weight_bank_loader
    import weight_bank_loader_pkg::*;
#(
    parameter int WORD_W = WBL_WORD_W,
    parameter int DEPTH  = WBL_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    weight_bank_loader_if.slave  bus,
    output dbg_t                 dbg
);

    localparam int              ADDR_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [ADDR_W:0] fill_q, fill_d;
    logic            err_q, err_d;
    wr_state_e       wr_state_q, wr_state_d;
    rd_state_e       rd_state_q, rd_state_d;

    logic            can_write;
    logic            accept;
    logic            rd_fire;

    assign can_write = (wr_state_q == W_FILL);
    assign accept    = bus.din_vld && can_write;
    assign rd_fire   = bus.rd_en && (rd_state_q == R_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            fill_q     <= '0;
            err_q      <= 1'b0;
            wr_state_q <= W_FILL;
            rd_state_q <= R_IDLE;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            fill_q     <= fill_d;
            err_q      <= err_d;
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
        end
    end

    always_comb begin
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        fill_d     = fill_q;
        err_d      = err_q;
        rd_state_d = rd_state_q;

        if (bus.din_vld && !can_write) begin
            err_d = 1'b1;
        end

        if (accept) begin
            if (fill_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                fill_d            = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                fill_d = fill_q + (ADDR_W + 1)'(1);
            end
        end

        // The write bank only ever equals a non-full bank and the read bank is full
        // while busy, so a simultaneous release and completion touch different flags.
        case (rd_state_q)
            R_IDLE: begin
                if (bus.bank_done) begin
                    err_d = 1'b1;
                end
                if (full_q[rd_bank_q]) begin
                    rd_state_d = R_BUSY;
                end
            end
            R_BUSY: begin
                if (bus.bank_done) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    // A bank that was already full keeps bank_vld high across the swap.
                    rd_state_d        = full_q[~rd_bank_q] ? R_BUSY : R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        wr_state_d = full_d[wr_bank_d] ? W_STALL : W_FILL;
    end

    always_comb begin
        bus.ready    = can_write;
        bus.bank_vld = (rd_state_q == R_BUSY);
        bus.fill_cnt = fill_q;
        bus.err      = err_q;

        dbg.wr_state = wr_state_q;
        dbg.rd_state = rd_state_q;
        dbg.wr_bank  = wr_bank_q;
        dbg.rd_bank  = rd_bank_q;
        dbg.full     = full_q;
    end

    weight_bank_ram #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .waddr ({wr_bank_q, fill_q[ADDR_W-1:0]}),
        .wdata (bus.din),
        .re    (rd_fire),
        .raddr ({rd_bank_q, bus.rd_addr}),
        .rdata (bus.rd_data)
    );

endmodule

// File: tb/tb_weight_bank_loader.sv
// Bench for weight_bank_loader: directed scenarios with literal expectations, then
// random traffic, all outputs compared every cycle against a bank-count model.
module tb_weight_bank_loader;
    import weight_bank_loader_pkg::*;

    localparam int W     = 256;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    weight_bank_loader_if #(.WORD_W(W), .ADDR_W(AW)) bus ();
    dbg_t dbg;

    weight_bank_loader #(.WORD_W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .dbg (dbg)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: banks are filled and released strictly in order, so the
    // whole state is the number of full banks, the oldest bank and the fill position.
    logic [W-1:0] m_mem [2][DEPTH];
    int           m_nfull = 0;
    bit           m_rd_bank = 1'b0;
    int           m_fill = 0;
    bit           m_err = 1'b0;
    bit           m_vld = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_rd_last = '0;

    always @(posedge clk) begin
        int nfull_now;
        bit ready_now;
        bit busy_now;
        bit wb;
        bit completed;
        if (rst) begin
            m_nfull   = 0;
            m_rd_bank = 1'b0;
            m_fill    = 0;
            m_err     = 1'b0;
            m_vld     = 1'b0;
            m_rd_last = '0;
            exp_q.delete();
        end else begin
            nfull_now = m_nfull;
            ready_now = (m_nfull < 2);
            busy_now  = m_vld;
            wb        = m_rd_bank ^ m_nfull[0];
            completed = 1'b0;
            if (bus.rd_en && busy_now) exp_q.push_back(m_mem[m_rd_bank][bus.rd_addr]);
            if (bus.din_vld && !ready_now) m_err = 1'b1;
            if (bus.bank_done && !busy_now) m_err = 1'b1;
            if (bus.din_vld && ready_now) begin
                m_mem[wb][m_fill] = bus.din;
                m_fill++;
                if (m_fill == DEPTH) begin
                    m_fill    = 0;
                    completed = 1'b1;
                end
            end
            if (bus.bank_done && busy_now) begin
                m_nfull--;
                m_rd_bank = !m_rd_bank;
                m_vld     = (nfull_now == 2);
            end else if (!busy_now && nfull_now > 0) begin
                m_vld = 1'b1;
            end
            if (completed) m_nfull++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0) m_rd_last = exp_q.pop_front();
            chk("ready",    bus.ready,    W'(m_nfull < 2));
            chk("bank_vld", bus.bank_vld, W'(m_vld));
            chk("fill_cnt", bus.fill_cnt, W'(m_fill));
            chk("err",      bus.err,      W'(m_err));
            chk("rd_data",  bus.rd_data,  m_rd_last);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.din_vld = 1'b0;
        bus.bank_done = 1'b0;
        bus.rd_en = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        int t = 0;
        while (!bus.ready && t < 200) begin
            step();
            t++;
        end
        chk("push_ready", W'(bus.ready), W'(1));
        bus.din = w;
        bus.din_vld = 1'b1;
        step();
        bus.din_vld = 1'b0;
    endtask

    task automatic read_word(input int a, input logic [W-1:0] exp, input string name);
        bus.rd_en = 1'b1;
        bus.rd_addr = AW'(a);
        step();
        bus.rd_en = 1'b0;
        chk(name, bus.rd_data, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected it to end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.din = '0;
        bus.din_vld = 1'b0;
        bus.rd_en = 1'b0;
        bus.rd_addr = '0;
        bus.bank_done = 1'b0;
        do_reset();
        chk_en = 1'b1;

        chk("rst_ready", W'(bus.ready), W'(1));
        chk("rst_bank_vld", W'(bus.bank_vld), W'(0));
        chk("rst_fill_cnt", W'(bus.fill_cnt), W'(0));
        chk("rst_err", W'(bus.err), W'(0));
        chk("rst_rd_data", bus.rd_data, W'(0));

        // First bank: words 0..63, bank_vld two cycles after the last word.
        for (int i = 0; i < 64; i++) push_word(W'(i));
        chk("b0_vld_early", W'(bus.bank_vld), W'(0));
        chk("b0_fill_wrap", W'(bus.fill_cnt), W'(0));
        step();
        chk("b0_vld", W'(bus.bank_vld), W'(1));
        read_word(5, W'(5), "b0_addr5");
        step();
        chk("rd_hold", bus.rd_data, W'(5));

        // Second bank fills, then both are full and ready drops.
        for (int i = 64; i < 128; i++) push_word(W'(i));
        chk("both_full_ready", W'(bus.ready), W'(0));
        bus.din = '1;
        bus.din_vld = 1'b1;
        step();
        step();
        bus.din_vld = 1'b0;
        chk("drop_err", W'(bus.err), W'(1));
        chk("drop_fill", W'(bus.fill_cnt), W'(0));

        // Release bank 0: bank 1 is presented without a gap.
        bus.bank_done = 1'b1;
        step();
        bus.bank_done = 1'b0;
        chk("rel_ready", W'(bus.ready), W'(1));
        chk("rel_vld", W'(bus.bank_vld), W'(1));
        read_word(7, W'(71), "b1_addr7");
        read_word(63, W'(127), "b1_addr63");

        // Reset in the middle of a fill discards everything.
        do_reset();
        for (int i = 0; i < 30; i++) push_word(W'(1000 + i));
        rst = 1'b1;
        step();
        chk("mid_rst_fill", W'(bus.fill_cnt), W'(0));
        chk("mid_rst_vld", W'(bus.bank_vld), W'(0));
        chk("mid_rst_ready", W'(bus.ready), W'(1));
        chk("mid_rst_err", W'(bus.err), W'(0));
        rst = 1'b0;
        for (int i = 0; i < 64; i++) push_word(W'(2000 + i));
        step();
        chk("refill_vld", W'(bus.bank_vld), W'(1));
        read_word(0, W'(2000), "refill_addr0");
        read_word(63, W'(2063), "refill_addr63");

        // Release of bank 0 on the same edge as the last word of bank 1.
        for (int i = 0; i < 63; i++) push_word(W'(3000 + i));
        bus.din = W'(3063);
        bus.din_vld = 1'b1;
        bus.bank_done = 1'b1;
        step();
        bus.din_vld = 1'b0;
        bus.bank_done = 1'b0;
        chk("same_edge_ready", W'(bus.ready), W'(1));
        chk("same_edge_fill", W'(bus.fill_cnt), W'(0));
        chk("same_edge_vld0", W'(bus.bank_vld), W'(0));
        step();
        chk("same_edge_vld1", W'(bus.bank_vld), W'(1));
        read_word(63, W'(3063), "same_edge_addr63");
        read_word(0, W'(3000), "same_edge_addr0");
        chk("same_edge_err", W'(bus.err), W'(0));

        // Release while nothing is presented is a protocol error.
        do_reset();
        bus.bank_done = 1'b1;
        step();
        bus.bank_done = 1'b0;
        chk("idle_done_err", W'(bus.err), W'(1));
        chk("idle_done_vld", W'(bus.bank_vld), W'(0));

        // Random traffic with rare protocol violations and resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < W / 32; k++) bus.din[k*32 +: 32] = $urandom();
            bus.din_vld = bus.ready ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 199) == 0);
            bus.bank_done = bus.bank_vld ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 299) == 0);
            bus.rd_en = ($urandom_range(0, 1) == 1);
            bus.rd_addr = AW'($urandom_range(0, DEPTH - 1));
            rst = ($urandom_range(0, 1499) == 0);
            step();
        end
        bus.din_vld = 1'b0;
        bus.bank_done = 1'b0;
        bus.rd_en = 1'b0;
        rst = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/weight_bank_loader.md
WEIGHT_BANK_LOADER -- requirements
Module: weight_bank_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 256, width of one input word (32 int8 weights).
REQ-002 SHALL have parameter DEPTH, default 64, words per bank; ADDR_W = clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port din  input  WORD_W  word from upstream byte-packing FIFO.
REQ-006 SHALL have port din_vld  input  1  din valid; upstream asserts only while ready=1.
REQ-007 SHALL have port ready  output  1  loader can accept a word this cycle.
REQ-008 SHALL have port rd_en  input  1  compute-side read strobe.
REQ-009 SHALL have port rd_addr  input  ADDR_W  word address within the active read bank.
REQ-010 SHALL have port rd_data  output  WORD_W  read data, 1-cycle latency.
REQ-011 SHALL have port bank_vld  output  1  a full bank is presented to compute side.
REQ-012 SHALL have port bank_done  input  1  one-cycle pulse: compute side releases the current bank.
REQ-013 SHALL have port fill_cnt  output  ADDR_W+1  words written into the current write bank.
REQ-014 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL hold two banks (0,1), each DEPTH x WORD_W, with per-bank full flags full[1:0].
REQ-016 SHALL accept a word when din_vld=1 and ready=1, writing it to bank wr_bank at address fill_cnt; fill_cnt increments by 1.
REQ-017 SHALL, on the acceptance that makes fill_cnt reach DEPTH, set full[wr_bank], clear fill_cnt to 0 and toggle wr_bank in the same edge.
REQ-018 SHALL drive ready = ~full[wr_bank], combinationally from registered state only, never from din_vld.
REQ-019 Write FSM SHALL have states W_FILL (ready=1) and W_STALL (ready=0); W_FILL->W_STALL when the new wr_bank is full; W_STALL->W_FILL in the cycle after that bank is released.
REQ-020 Read FSM SHALL have states R_IDLE (bank_vld=0) and R_BUSY (bank_vld=1); R_IDLE->R_BUSY when full[rd_bank]=1; R_BUSY->R_IDLE on bank_done.
REQ-021 SHALL, on bank_done in R_BUSY, clear full[rd_bank] and toggle rd_bank.
REQ-022 SHALL register rd_data from bank rd_bank, address rd_addr, one cycle after rd_en=1; rd_data holds its previous value when rd_en=0.
REQ-023 SHALL assert bank_vld no earlier than the cycle after the last word of that bank is written.
REQ-024 SHALL, when bank_done and a bank-completing write occur on the same edge, apply both: the released bank is immediately writable, and the completed bank is marked full.
REQ-025 SHALL set err on din_vld=1 while ready=0 (word dropped, no state change) or on bank_done in R_IDLE (ignored); err clears only on reset.
REQ-026 SHALL ignore rd_en outside R_BUSY (rd_data unchanged).
REQ-027 Throughput SHALL be one word per cycle while a bank is free; no bubble at bank switch.

Reset
REQ-028 On rst=1, SHALL clear full[1:0], wr_bank, rd_bank, fill_cnt, err and rd_data to 0, and enter W_FILL/R_IDLE; ready=1 and bank_vld=0 in the first cycle after reset.
REQ-029 Reset mid-fill SHALL discard partial and full banks; RAM contents need not be cleared.

Structure
REQ-030 WORD_W, DEPTH-derived ADDR_W, and the write/read FSM state encodings SHALL live in the shared accelerator package.
REQ-031 Storage SHALL be one sub-module, weight_bank_ram: simple dual-port RAM of 2*DEPTH x WORD_W, address = {bank, addr}, registered read.

Verification
REQ-032 Reset, then stream 64 words with values 0..63 -> bank_vld=1 two cycles after word 63; reading addr 5 returns 5 one cycle after rd_en.
REQ-033 Stream 128 words back-to-back with no bank_done -> ready drops the cycle after word 127; din_vld forced while ready=0 -> err=1 and bank contents unchanged.
REQ-034 With both banks full, pulse bank_done -> ready=1 next cycle; rd_bank=1, and bank_vld stays 1, now presenting bank 1 (words 64..127).
REQ-035 bank_done on the same edge as word 127 of bank 1 is accepted -> bank 0 freed, bank 1 full, no word lost, ready remains 1.
REQ-036 Assert rst after 30 words -> fill_cnt=0, bank_vld=0, ready=1; the next 64 words fill bank 0 from address 0.
